// File: rtl/sys_defs.sv
// Shared machine-wide typedefs used by the front end and dispatch.
// Pure type package: no logic, no latency.
// No flow control of its own.
package sys_defs;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst;
    logic [31:0] pc;
  } FETCH_PACKET;

endpackage

// File: rtl/lane_compact.sv
// Compacts sparse valid lanes into dense destination offsets, capped at a limit.
// Purely combinational, zero latency.
// Lanes beyond the limit are reported as not accepted; the caller re-presents them.
module lane_compact #(
  parameter int W = 4
) (
  input  logic [W-1:0]                     valid,
  input  logic [$clog2(W+1)-1:0]           limit,
  output logic [W-1:0][$clog2(W+1)-1:0]    offset,
  output logic [W-1:0]                     accept,
  output logic [$clog2(W+1)-1:0]           count
);

  localparam int CW = $clog2(W+1);

  logic [CW-1:0] run;

  always_comb begin
    run    = '0;
    count  = '0;
    offset = '0;
    accept = '0;
    for (int i = 0; i < W; i++) begin
      // offset is the rank of this lane among valid lanes below it
      offset[i] = run;
      accept[i] = valid[i] && (run < limit);
      if (accept[i]) count = count + CW'(1);
      if (valid[i])  run   = run + CW'(1);
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// In-order instruction queue: sparse multi-lane push from fetch, windowed pop to dispatch.
// Push-to-window latency 1 cycle; push_accepted is same-cycle combinational.
// Fetch is throttled by push_accepted (free space from current count only); pops are clamped.
module fetch_queue
  import sys_defs::*;
#(
  parameter int DEPTH        = 16,
  parameter int PUSH_W       = 4,
  parameter int POP_W        = 3,
  parameter int AFULL_THRESH = DEPTH - PUSH_W
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  FETCH_PACKET [PUSH_W-1:0]      push_entries,
  output logic [$clog2(PUSH_W+1)-1:0]   push_accepted,
  input  logic [$clog2(POP_W+1)-1:0]    pop_req,
  output FETCH_PACKET [POP_W-1:0]       window,
  output logic [$clog2(POP_W+1)-1:0]    window_count,
  output logic [$clog2(DEPTH+1)-1:0]    free_slots,
  output logic                          almost_full,
  output logic                          err_underflow,
  output logic                          err_overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int PA_W  = $clog2(PUSH_W+1);
  localparam int PR_W  = $clog2(POP_W+1);

  FETCH_PACKET            mem [DEPTH];
  logic [PTR_W-1:0]       head, tail;
  logic [CNT_W-1:0]       count, count_next, actual_pops;
  logic [PUSH_W-1:0]      lane_valid, lane_accept;
  logic [PUSH_W-1:0][PA_W-1:0] lane_offset;
  logic [PA_W-1:0]        limit, nv;
  logic                   underflow_hit, overflow_hit;

  always_comb begin
    nv = '0;
    for (int i = 0; i < PUSH_W; i++) begin
      lane_valid[i] = push_entries[i].valid;
      if (push_entries[i].valid) nv = nv + PA_W'(1);
    end
  end

  assign free_slots = CNT_W'(DEPTH) - count;

  // Same-cycle pops deliberately do not free space for pushes.
  always_comb begin
    limit = '0;
    if (!flush) begin
      if (free_slots >= CNT_W'(PUSH_W)) limit = PA_W'(PUSH_W);
      else                              limit = PA_W'(free_slots);
    end
  end

  lane_compact #(.W(PUSH_W)) u_compact (
    .valid  (lane_valid),
    .limit  (limit),
    .offset (lane_offset),
    .accept (lane_accept),
    .count  (push_accepted)
  );

  assign underflow_hit = CNT_W'(pop_req) > count;
  assign overflow_hit  = CNT_W'(nv) > free_slots;
  assign actual_pops   = underflow_hit ? count : CNT_W'(pop_req);
  assign count_next    = count - actual_pops + CNT_W'(push_accepted);

  assign window_count = (count >= CNT_W'(POP_W)) ? PR_W'(POP_W) : PR_W'(count);
  assign almost_full  = count >= CNT_W'(AFULL_THRESH);

  always_comb begin
    window = '0;
    for (int i = 0; i < POP_W; i++) begin
      if (CNT_W'(i) < count) window[i] = mem[head + PTR_W'(i)];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      count         <= '0;
      err_underflow <= 1'b0;
      err_overflow  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      for (int i = 0; i < PUSH_W; i++) begin
        if (lane_accept[i]) mem[tail + PTR_W'(lane_offset[i])] <= push_entries[i];
      end
      head  <= head + PTR_W'(actual_pops);
      tail  <= tail + PTR_W'(push_accepted);
      count <= count_next;
      if (underflow_hit) err_underflow <= 1'b1;
      if (overflow_hit)  err_overflow  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed-vector bench for fetch_queue with a queue scoreboard for window contents.
module tb_fetch_queue;
  import sys_defs::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              flush;
  FETCH_PACKET [3:0] push_entries;
  logic [2:0]        push_accepted;
  logic [1:0]        pop_req;
  FETCH_PACKET [2:0] window;
  logic [1:0]        window_count;
  logic [4:0]        free_slots;
  logic              almost_full;
  logic              err_underflow;
  logic              err_overflow;

  fetch_queue dut (
    .clock         (clock),
    .reset         (reset),
    .flush         (flush),
    .push_entries  (push_entries),
    .push_accepted (push_accepted),
    .pop_req       (pop_req),
    .window        (window),
    .window_count  (window_count),
    .free_slots    (free_slots),
    .almost_full   (almost_full),
    .err_underflow (err_underflow),
    .err_overflow  (err_overflow)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  int          uid      = 0;
  int          total_acc = 0;
  FETCH_PACKET model_q[$];
  logic        m_eu, m_eo;

  typedef struct {
    logic       fl;
    logic [3:0] mask;
    logic [1:0] pop;
    int         pa;
    int         wc;
    int         fs;
    int         af;
    int         eo;
    int         eu;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_pkt(input string name, input FETCH_PACKET act, input FETCH_PACKET exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic FETCH_PACKET mk(input int id);
    FETCH_PACKET p;
    p.valid = 1'b1;
    p.pc    = 32'h1000 + 32'(id) * 4;
    p.inst  = 32'hA5A5_0000 ^ 32'(id);
    return p;
  endfunction

  task automatic check_state(input string tag);
    int sz;
    FETCH_PACKET e;
    sz = model_q.size();
    chk({tag, "_window_count"}, int'(window_count), (sz < 3) ? sz : 3);
    chk({tag, "_free_slots"}, int'(free_slots), 16 - sz);
    chk({tag, "_almost_full"}, int'(almost_full), (sz >= 12) ? 1 : 0);
    chk({tag, "_err_overflow"}, int'(err_overflow), int'(m_eo));
    chk({tag, "_err_underflow"}, int'(err_underflow), int'(m_eu));
    for (int i = 0; i < 3; i++) begin
      e = (i < sz) ? model_q[i] : '0;
      chk_pkt($sformatf("%s_window%0d", tag, i), window[i], e);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset        = 1'b1;
    flush        = 1'b0;
    pop_req      = '0;
    push_entries = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    model_q.delete();
    m_eu = 1'b0;
    m_eo = 1'b0;
    check_state("reset");
  endtask

  task automatic step(input string tag, input logic fl, input logic [3:0] mask,
                      input logic [1:0] pr, output int pa_seen);
    FETCH_PACKET lanes[4];
    int nv, free, pa, pops, n;
    @(negedge clock);
    flush   = fl;
    pop_req = pr;
    for (int l = 0; l < 4; l++) begin
      if (mask[l]) begin
        lanes[l] = mk(uid);
        uid++;
      end else begin
        lanes[l] = '0;
      end
      push_entries[l] = lanes[l];
    end
    nv   = $countones(mask);
    free = 16 - model_q.size();
    pa   = fl ? 0 : ((nv < free) ? nv : free);
    #1;
    pa_seen = int'(push_accepted);
    chk({tag, "_push_accepted"}, pa_seen, pa);
    if (fl) begin
      model_q.delete();
    end else begin
      if (int'(pr) > model_q.size()) m_eu = 1'b1;
      pops = (int'(pr) < model_q.size()) ? int'(pr) : model_q.size();
      repeat (pops) void'(model_q.pop_front());
      if (nv > free) m_eo = 1'b1;
      n = 0;
      for (int l = 0; l < 4; l++) begin
        if (mask[l] && n < pa) begin
          model_q.push_back(lanes[l]);
          n++;
        end
      end
      total_acc += pa;
    end
    @(posedge clock);
    #1;
    check_state(tag);
    flush        = 1'b0;
    pop_req      = '0;
    push_entries = '0;
  endtask

  initial begin
    vec_t tbl[19];
    int   pa_seen;

    tbl[0]  = '{1'b0, 4'hF, 2'd0, 4, 3, 12, 0, 0, 0};
    tbl[1]  = '{1'b1, 4'h0, 2'd0, 0, 0, 16, 0, 0, 0};
    tbl[2]  = '{1'b0, 4'hA, 2'd0, 2, 2, 14, 0, 0, 0};
    tbl[3]  = '{1'b0, 4'hF, 2'd2, 4, 3, 12, 0, 0, 0};
    tbl[4]  = '{1'b0, 4'hF, 2'd0, 4, 3,  8, 0, 0, 0};
    tbl[5]  = '{1'b0, 4'hF, 2'd0, 4, 3,  4, 1, 0, 0};
    tbl[6]  = '{1'b0, 4'h3, 2'd0, 2, 3,  2, 1, 0, 0};
    tbl[7]  = '{1'b0, 4'hF, 2'd0, 2, 3,  0, 1, 1, 0};
    tbl[8]  = '{1'b0, 4'hF, 2'd3, 0, 3,  3, 1, 1, 0};
    tbl[9]  = '{1'b0, 4'h0, 2'd3, 0, 3,  6, 0, 1, 0};
    tbl[10] = '{1'b0, 4'h0, 2'd3, 0, 3,  9, 0, 1, 0};
    tbl[11] = '{1'b0, 4'h0, 2'd3, 0, 3, 12, 0, 1, 0};
    tbl[12] = '{1'b0, 4'h0, 2'd2, 0, 2, 14, 0, 1, 0};
    tbl[13] = '{1'b0, 4'h0, 2'd3, 0, 0, 16, 0, 1, 1};
    tbl[14] = '{1'b1, 4'hF, 2'd3, 0, 0, 16, 0, 1, 1};
    tbl[15] = '{1'b0, 4'hF, 2'd0, 4, 3, 12, 0, 1, 1};
    tbl[16] = '{1'b0, 4'hF, 2'd0, 4, 3,  8, 0, 1, 1};
    tbl[17] = '{1'b0, 4'h1, 2'd0, 1, 3,  7, 0, 1, 1};
    tbl[18] = '{1'b1, 4'hF, 2'd2, 0, 0, 16, 0, 1, 1};

    reset        = 1'b1;
    flush        = 1'b0;
    pop_req      = '0;
    push_entries = '0;
    m_eu         = 1'b0;
    m_eo         = 1'b0;

    do_reset();

    for (int v = 0; v < 19; v++) begin
      step($sformatf("vec%0d", v), tbl[v].fl, tbl[v].mask, tbl[v].pop, pa_seen);
      chk($sformatf("vec%0d_hand_pa", v), pa_seen, tbl[v].pa);
      chk($sformatf("vec%0d_hand_wc", v), int'(window_count), tbl[v].wc);
      chk($sformatf("vec%0d_hand_free", v), int'(free_slots), tbl[v].fs);
      chk($sformatf("vec%0d_hand_afull", v), int'(almost_full), tbl[v].af);
      chk($sformatf("vec%0d_hand_eo", v), int'(err_overflow), tbl[v].eo);
      chk($sformatf("vec%0d_hand_eu", v), int'(err_underflow), tbl[v].eu);
    end

    // Sticky flags survive flushes and clear only on reset.
    do_reset();
    chk("flags_cleared_eo", int'(err_overflow), 0);
    chk("flags_cleared_eu", int'(err_underflow), 0);

    total_acc = 0;
    for (int i = 0; i < 40; i++) begin
      step($sformatf("wrap%0d", i), 1'b0, 4'((i * 7 + 3) % 16), 2'(i % 4), pa_seen);
    end
    chk("wrap_total_pushes_ge_32", (total_acc >= 32) ? 1 : 0, 1);

    do_reset();
    step("pre_rst0", 1'b0, 4'hF, 2'd0, pa_seen);
    step("pre_rst1", 1'b0, 4'h5, 2'd1, pa_seen);
    @(negedge clock);
    reset        = 1'b1;
    push_entries = {mk(900), mk(901), mk(902), mk(903)};
    pop_req      = 2'd1;
    @(posedge clock);
    #1;
    chk("midrst_window_count", int'(window_count), 0);
    chk("midrst_free_slots", int'(free_slots), 16);
    chk_pkt("midrst_window0", window[0], '0);
    reset        = 1'b0;
    push_entries = '0;
    pop_req      = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
